// File: rtl/alu_pkg.sv
// Shared ALU encodings and request/response types for the shared-ALU arbiter.
package alu_pkg;

    localparam logic [6:0] OP_REG     = 7'b0110011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] FUNCT7_ALT = 7'h20;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_TAG_W  = 5;

    // Request record at the default widths (32-bit data, 5-bit tag).
    typedef struct packed {
        logic [6:0]            opcode;
        logic [6:0]            funct7;
        logic [2:0]            funct3;
        logic [ALU_DATA_W-1:0] rs1;
        logic [ALU_DATA_W-1:0] rs2;
        logic [31:0]           imm;
        logic [ALU_TAG_W-1:0]  tag;
    } alu_req_t;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU for register-register and register-immediate ops.
// Unknown opcodes produce a zero result.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 31
) (
    input  logic [6:0]          opcode,
    input  logic [6:0]          funct7,
    input  logic [2:0]          funct3,
    input  logic [DATA_WIDTH:0] rs1,
    input  logic [DATA_WIDTH:0] rs2,
    input  logic [31:0]         imm,
    output logic [DATA_WIDTH:0] result
);

    localparam int W   = DATA_WIDTH + 1;
    localparam int SHW = $clog2(W);

    logic [W-1:0]   imm_ext;
    logic [W-1:0]   op2;
    logic [SHW-1:0] shamt;
    logic           alt_sub;
    logic           alt_sra;

    generate
        if (W > 32) begin : g_imm_sext
            assign imm_ext = {{(W-32){imm[31]}}, imm};
        end else begin : g_imm_trunc
            assign imm_ext = imm[W-1:0];
        end
    endgenerate

    always_comb begin
        result  = '0;
        op2     = (opcode == OP_IMM) ? imm_ext : rs2;
        shamt   = op2[SHW-1:0];
        // Immediate forms have no SUB; SRAI is flagged by imm bit 10.
        alt_sub = (opcode == OP_REG) && (funct7 == FUNCT7_ALT);
        alt_sra = (opcode == OP_REG) ? (funct7 == FUNCT7_ALT) : imm[10];
        if ((opcode == OP_REG) || (opcode == OP_IMM)) begin
            case (funct3)
                3'd0: result = alt_sub ? (rs1 - op2) : (rs1 + op2);
                3'd1: result = rs1 << shamt;
                3'd2: result = {{(W-1){1'b0}}, ($signed(rs1) < $signed(op2))};
                3'd3: result = {{(W-1){1'b0}}, (rs1 < op2)};
                3'd4: result = rs1 ^ op2;
                3'd5: result = alt_sra ? W'($signed(rs1) >>> shamt) : (rs1 >> shamt);
                3'd6: result = rs1 | op2;
                default: result = rs1 & op2;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between two requesters, with a single
// registered response slot. Optional counters: ALU_SHARE_ARB_PERF_EN.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 31,
    parameter int TAG_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic [1:0]            i_req_valid,
    output logic [1:0]            o_req_ready,
    input  logic [6:0]            i_req0_opcode,
    input  logic [6:0]            i_req0_funct7,
    input  logic [2:0]            i_req0_funct3,
    input  logic [DATA_WIDTH:0]   i_req0_rs1,
    input  logic [DATA_WIDTH:0]   i_req0_rs2,
    input  logic [31:0]           i_req0_imm,
    input  logic [TAG_W-1:0]      i_req0_tag,
    input  logic [6:0]            i_req1_opcode,
    input  logic [6:0]            i_req1_funct7,
    input  logic [2:0]            i_req1_funct3,
    input  logic [DATA_WIDTH:0]   i_req1_rs1,
    input  logic [DATA_WIDTH:0]   i_req1_rs2,
    input  logic [31:0]           i_req1_imm,
    input  logic [TAG_W-1:0]      i_req1_tag,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_id,
    output logic [TAG_W-1:0]      o_rsp_tag,
    output logic [DATA_WIDTH:0]   o_rsp_data
`ifdef ALU_SHARE_ARB_PERF_EN
    ,
    output logic [31:0]           o_perf_grant0,
    output logic [31:0]           o_perf_grant1,
    output logic [31:0]           o_perf_stall
`endif
);

    typedef struct packed {
        logic [6:0]          opcode;
        logic [6:0]          funct7;
        logic [2:0]          funct3;
        logic [DATA_WIDTH:0] rs1;
        logic [DATA_WIDTH:0] rs2;
        logic [31:0]         imm;
        logic [TAG_W-1:0]    tag;
    } req_t;

    req_t                req0, req1, sel;
    rsp_state_t          state_reg, state_next;
    logic                prio_reg;
    logic                rsp_id_reg;
    logic [TAG_W-1:0]    rsp_tag_reg;
    logic [DATA_WIDTH:0] rsp_data_reg;
    logic [DATA_WIDTH:0] alu_result;
    logic                can_accept;
    logic                has_grant;
    logic                grant;
    logic                fire;

    assign req0 = '{opcode: i_req0_opcode, funct7: i_req0_funct7, funct3: i_req0_funct3,
                    rs1: i_req0_rs1, rs2: i_req0_rs2, imm: i_req0_imm, tag: i_req0_tag};
    assign req1 = '{opcode: i_req1_opcode, funct7: i_req1_funct7, funct3: i_req1_funct3,
                    rs1: i_req1_rs1, rs2: i_req1_rs2, imm: i_req1_imm, tag: i_req1_tag};

    assign o_rsp_valid = (state_reg == RSP_FULL);
    assign can_accept  = clk_en & ~rst & (~o_rsp_valid | i_rsp_ready);
    assign has_grant   = |i_req_valid;
    // Contention resolves by the pointer; a lone requester always wins.
    assign grant       = (&i_req_valid) ? prio_reg : i_req_valid[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign o_req_ready[gi] = can_accept & (grant == 1'(gi)) & i_req_valid[gi];
        end
    endgenerate

    assign fire = |(i_req_valid & o_req_ready);
    assign sel  = has_grant ? (grant ? req1 : req0) : '0;

    alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .opcode (sel.opcode),
        .funct7 (sel.funct7),
        .funct3 (sel.funct3),
        .rs1    (sel.rs1),
        .rs2    (sel.rs2),
        .imm    (sel.imm),
        .result (alu_result)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RSP_EMPTY: if (fire) state_next = RSP_FULL;
            RSP_FULL: begin
                if (fire)             state_next = RSP_FULL;
                else if (i_rsp_ready) state_next = RSP_EMPTY;
            end
            default: state_next = RSP_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RSP_EMPTY;
            prio_reg     <= 1'b0;
            rsp_id_reg   <= 1'b0;
            rsp_tag_reg  <= '0;
            rsp_data_reg <= '0;
        end else if (clk_en) begin
            state_reg <= state_next;
            if (fire) begin
                rsp_data_reg <= alu_result;
                rsp_id_reg   <= grant;
                rsp_tag_reg  <= sel.tag;
                prio_reg     <= ~grant;
            end
        end
    end

    assign o_rsp_id   = rsp_id_reg;
    assign o_rsp_tag  = rsp_tag_reg;
    assign o_rsp_data = rsp_data_reg;

`ifdef ALU_SHARE_ARB_PERF_EN
    logic [31:0] stall_cnt_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf
            logic [31:0] cnt_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    cnt_reg <= '0;
                else if (fire && (grant == 1'(gi)))
                    cnt_reg <= cnt_reg + 32'd1;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_reg <= '0;
        else if (has_grant && !fire && clk_en)
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end

    assign o_perf_grant0 = g_perf[0].cnt_reg;
    assign o_perf_grant1 = g_perf[1].cnt_reg;
    assign o_perf_stall  = stall_cnt_reg;
`endif

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one `alu` instance between two requesters (req0 = main issue slot, req1 = secondary slot, e.g. address-generation or debug).
- Each requester has a valid/ready request channel.
- Arbitration is round-robin; the chosen operands drive the ALU combinationally.
- The ALU result is registered into a single-entry response buffer, tagged with the requester id and destination register, and drained through a valid/ready response channel.

Parameters:
- DATA_WIDTH, 31, MSB index of operand/result data (buses are DATA_WIDTH+1 bits wide).
- TAG_W, 5, width of the destination-register tag carried with each request.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  global clock enable; when low, no state changes
- i_req_valid  in  2  per-requester request valid (bit n = requester n)
- o_req_ready  out  2  per-requester accept (combinational)
- i_req0_opcode / i_req1_opcode  in  7  instruction opcode
- i_req0_funct7 / i_req1_funct7  in  7  funct7
- i_req0_funct3 / i_req1_funct3  in  3  funct3
- i_req0_rs1 / i_req1_rs1  in  DATA_WIDTH+1  operand 1
- i_req0_rs2 / i_req1_rs2  in  DATA_WIDTH+1  operand 2
- i_req0_imm / i_req1_imm  in  32  sign-extended immediate
- i_req0_tag / i_req1_tag  in  TAG_W  destination tag
- o_rsp_valid  out  1  response buffer full
- i_rsp_ready  in  1  consumer accepts response
- o_rsp_id  out  1  requester that issued the buffered result
- o_rsp_tag  out  TAG_W  tag of the buffered result
- o_rsp_data  out  DATA_WIDTH+1  ALU result

Behaviour:
- Clocking and reset:
  - One clock, clk; reset rst is synchronous and active-high.
  - On rst: o_rsp_valid=0, o_rsp_id=0, o_rsp_tag=0, o_rsp_data=0, priority pointer=0 (req0 favoured).
  - o_req_ready=0 while rst is high.
  - Reset mid-operation discards any buffered response; no partial transfer is reported.
- Acceptance:
  - can_accept = clk_en & ~rst & (~o_rsp_valid | i_rsp_ready).
- Grant (combinational):
  - Only req0 valid -> grant 0. Only req1 valid -> grant 1.
  - Both valid -> grant = priority pointer.
  - o_req_ready[n] = can_accept & grant==n & i_req_valid[n]. At most one bit is set per cycle.
- Mux:
  - The granted requester's opcode/funct7/funct3/rs1/rs2/imm drive the shared ALU.
  - With no grant, ALU inputs are driven to 0 (opcode 0 -> result 0).
- Transfer (fire = |(i_req_valid & o_req_ready)):
  - At posedge: o_rsp_data <= ALU result, o_rsp_id <= grant, o_rsp_tag <= granted tag, o_rsp_valid <= 1.
  - Latency is exactly 1 cycle from fire to o_rsp_valid.
  - Priority pointer <= ~grant after every fire, including single-requester fires.
- Drain:
  - o_rsp_valid & i_rsp_ready & ~fire -> o_rsp_valid <= 0.
  - Drain and fire in the same cycle -> buffer refilled and o_rsp_valid stays 1 (full throughput, 1 op/cycle).
- Stall: o_rsp_valid=1 & i_rsp_ready=0 -> both readies 0; o_rsp_* held stable.
- Requester rule: payload must be held constant while valid & ~ready. Deasserting valid before ready is permitted (request withdrawn, no effect).
- clk_en=0: all registers hold, readies forced 0, o_rsp_valid unchanged.
- Unsupported opcode/funct combinations pass through; the result is whatever the ALU yields (0 for unknown opcodes). No error flag.
- Response FSM states:
  - EMPTY -> FULL on fire.
  - FULL -> EMPTY on drain without fire.
  - FULL -> FULL on stall, or on drain with fire.

Optional Feature:
- Macro: ALU_SHARE_ARB_PERF_EN.
- Defined:
  - Extra outputs o_perf_grant0, o_perf_grant1, o_perf_stall, each 32 bits.
  - grantN counts fires for requester N. stall counts cycles with |i_req_valid & ~fire & clk_en.
  - Counters are cleared by rst and wrap modulo 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg (added to types.svh):
  - opcode constants OP_REG=7'b0110011, OP_IMM=7'b0010011
  - FUNCT7_ALT=7'h20
  - typedef alu_req_t (opcode, funct7, funct3, rs1, rs2, imm, tag)
  - typedef enum rsp_state_t {RSP_EMPTY, RSP_FULL}
- Sub-module: the existing `alu`, instantiated once. Arbitration, mux and buffer stay in alu_share_arb.

Test Plan:
- Reset check: after rst, o_rsp_valid=0, o_req_ready=0 during rst; first both-valid cycle after rst grants req0.
- Single op: req0 ADD (OP_REG, f3=0, f7=0) rs1=5, rs2=7, tag=3, rsp_ready=1 -> next cycle o_rsp_valid=1, data=12, id=0, tag=3.
- Contention: both valid continuously for 4 cycles, rsp_ready=1 -> grant order 0,1,0,1; o_rsp_id sequence 0,1,0,1 one cycle later; one result per cycle.
- Backpressure: buffer holds req1 SRAI rs1=0xFFFFFFF0, imm=0x402 (result 0xFFFFFFFC) with rsp_ready=0 for 3 cycles -> both readies 0 and data stable; then rsp_ready=1 with req0 valid drains and refills in the same cycle, o_rsp_valid stays 1.
- Freeze and abort: clk_en=0 for 2 cycles with requests pending -> no fire, state held. Then rst asserted with the buffer full -> o_rsp_valid=0 next cycle and the pending result is lost.
- Perf (ALU_SHARE_ARB_PERF_EN): run the contention test then 2 stall cycles -> grant0=2, grant1=2, stall=2.
